// File: rtl/demux_sched_pkg.sv
// Shared constants, state encoding and lane-select type for the round-robin demux scheduler.
package demux_sched_pkg;
  localparam int NUM_CH     = 8;
  localparam int SEL_W      = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {IDLE, HOLD} state_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_CH-1:0] lane_onehot(input sel_t s);
    return NUM_CH'(1) << s;
  endfunction
endpackage

// File: rtl/rr_lane_picker.sv
// Combinational round-robin search: first eligible lane at or after ptr, wrapping mod NUM_CH.
module rr_lane_picker
  import demux_sched_pkg::*;
(
  input  sel_t              ptr,
  input  logic [NUM_CH-1:0] mask,
  output sel_t              sel,
  output logic              any
);
  sel_t idx;

  // Scan from the far end back toward ptr so the nearest eligible lane is written last.
  always_comb begin
    sel = ptr;
    idx = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = ptr + sel_t'(i);
      if (mask[idx]) sel = idx;
    end
  end

  assign any = |mask;
endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin 1-to-8 demux with one-entry holding register.
// Optional build macro DEMUX_SCHED_STATS_EN adds delivery/stall counters.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output sel_t              cur_sel
`ifdef DEMUX_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_delivered,
  output logic [15:0]       stat_stall
`endif
);
  state_t            state_q;
  sel_t              rr_ptr_q;
  sel_t              sel_q;
  logic [DATA_W-1:0] data_q;
  logic [NUM_CH-1:0] out_valid_q;

  sel_t pick_ptr;
  sel_t pick_sel;
  logic pick_any;
  logic sel_ready;
  logic deliver;
  logic accept;

  // In HOLD the next item must follow the lane being released, not the stale rr_ptr.
  assign pick_ptr = (state_q == HOLD) ? sel_q + sel_t'(1) : rr_ptr_q;

  rr_lane_picker u_picker (
    .ptr  (pick_ptr),
    .mask (ch_mask),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  assign sel_ready = out_ready[sel_q];
  assign deliver   = (state_q == HOLD) && sel_ready;
  assign in_ready  = rst_n && enable && pick_any && ((state_q == IDLE) || sel_ready);
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign cur_sel   = (state_q == IDLE) ? rr_ptr_q : sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      out_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q      <= in_data;
            sel_q       <= pick_sel;
            out_valid_q <= lane_onehot(pick_sel);
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (deliver) begin
            rr_ptr_q <= sel_q + sel_t'(1);
            if (accept) begin
              data_q      <= in_data;
              sel_q       <= pick_sel;
              out_valid_q <= lane_onehot(pick_sel);
            end else begin
              out_valid_q <= '0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [15:0] stat_delivered_q;
  logic [15:0] stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_delivered_q <= '0;
      stat_stall_q     <= '0;
    end else begin
      if (deliver) stat_delivered_q <= stat_delivered_q + 16'd1;
      if ((state_q == HOLD) && !sel_ready) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_delivered = stat_delivered_q;
  assign stat_stall     = stat_stall_q;
`endif
endmodule
